// File: rtl/common.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : common                                                      |
// | Purpose    : Shared types for the CPU -> rasterizer command path:        |
// |              raster command codes, the queued command entry and the      |
// |              command-queue FSM state encoding.                           |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
package common;

    localparam int C_COORD_W  = 8;
    localparam int C_COLOUR_W = 3;

    // Rasterizer operation codes.
    typedef enum logic [1:0] {
        CMD_CLEAR = 2'd0,
        CMD_PIXEL = 2'd1,
        CMD_LINE  = 2'd2,
        CMD_RECT  = 2'd3
    } raster_command_t;

    // One queued command with all of its operands.
    typedef struct packed {
        raster_command_t         command;
        logic [C_COORD_W-1:0]    x0;
        logic [C_COORD_W-1:0]    y0;
        logic [C_COORD_W-1:0]    x1;
        logic [C_COORD_W-1:0]    y1;
        logic [C_COLOUR_W-1:0]   colour;
    } gpu_cmd_entry_t;

    // Issue FSM states, explicitly encoded.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ACK   = 2'd2,
        ST_RUN   = 2'd3
    } gpu_fsm_state_t;

endpackage
`default_nettype wire

// File: rtl/gpu_cmd_queue_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface  : gpu_cmd_queue_if                                            |
// | Purpose    : Bundles the CPU enqueue side and the rasterizer issue side  |
// |              of the command queue.                                       |
// | Ports      : slave  - the queue (takes push/in_*/flush/gpu_busy, drives  |
// |                       full/count/idle and the gpu_* issue signals)       |
// |              master - the CPU + rasterizer environment                   |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
interface gpu_cmd_queue_if
    import common::*;
#(
    parameter int DEPTH = 4
) ();

    // CPU enqueue side
    logic                      push;
    raster_command_t           in_command;
    logic [C_COORD_W-1:0]      in_x0;
    logic [C_COORD_W-1:0]      in_y0;
    logic [C_COORD_W-1:0]      in_x1;
    logic [C_COORD_W-1:0]      in_y1;
    logic [C_COLOUR_W-1:0]     in_colour;
    logic                      flush;
    logic                      full;
    logic [$clog2(DEPTH):0]    count;
    logic                      idle;

    // Rasterizer issue side
    raster_command_t           gpu_command;
    logic [C_COORD_W-1:0]      gpu_x0;
    logic [C_COORD_W-1:0]      gpu_y0;
    logic [C_COORD_W-1:0]      gpu_x1;
    logic [C_COORD_W-1:0]      gpu_y1;
    logic [C_COLOUR_W-1:0]     gpu_colour;
    logic                      gpu_execute_request;
    logic                      gpu_busy;

    modport master (
        output push, in_command, in_x0, in_y0, in_x1, in_y1, in_colour, flush,
        output gpu_busy,
        input  full, count, idle,
        input  gpu_command, gpu_x0, gpu_y0, gpu_x1, gpu_y1, gpu_colour,
        input  gpu_execute_request
    );

    modport slave (
        input  push, in_command, in_x0, in_y0, in_x1, in_y1, in_colour, flush,
        input  gpu_busy,
        output full, count, idle,
        output gpu_command, gpu_x0, gpu_y0, gpu_x1, gpu_y1, gpu_colour,
        output gpu_execute_request
    );

endinterface
`default_nettype wire

// File: rtl/cmd_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : cmd_fifo                                                    |
// | Purpose    : Circular FIFO with wrapping read/write pointers and an      |
// |              occupancy counter. Head data is presented combinationally.  |
// | Ports      : clk, rst          clock, synchronous active-high reset      |
// |              i_push, i_wdata   enqueue request and data                  |
// |              i_pop             dequeue request (ignored when empty)      |
// |              i_flush           discard all entries (beats push and pop)  |
// |              o_rdata           head entry                                |
// |              o_full, o_empty   occupancy flags                           |
// |              o_count           number of stored entries                  |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic                    i_push,
    input  wire logic                    i_pop,
    input  wire logic                    i_flush,
    input  wire logic [WIDTH-1:0]        i_wdata,
    output logic      [WIDTH-1:0]        o_rdata,
    output logic                         o_full,
    output logic                         o_empty,
    output logic      [$clog2(DEPTH):0]  o_count
);

    localparam int                C_AW       = $clog2(DEPTH);
    localparam logic [C_AW:0]     C_FULL_CNT = (C_AW+1)'(DEPTH);
    localparam logic [C_AW:0]     C_CNT_ONE  = (C_AW+1)'(1);
    localparam logic [C_AW-1:0]   C_PTR_ONE  = C_AW'(1);

    // Storage carries no reset; only pointers and count define validity.
    logic [WIDTH-1:0]  r_mem_q [DEPTH];

    logic [C_AW-1:0]   r_wr_ptr_q;
    logic [C_AW-1:0]   w_wr_ptr_d;
    logic [C_AW-1:0]   r_rd_ptr_q;
    logic [C_AW-1:0]   w_rd_ptr_d;
    logic [C_AW:0]     r_count_q;
    logic [C_AW:0]     w_count_d;
    logic              w_wr_en;
    logic              w_rd_en;

    assign o_full  = (r_count_q == C_FULL_CNT);
    assign o_empty = (r_count_q == '0);
    assign o_count = r_count_q;
    assign o_rdata = r_mem_q[r_rd_ptr_q];

    always_comb begin
        w_rd_en    = i_pop && !o_empty;
        // A full FIFO still accepts a push when the head leaves the same cycle.
        w_wr_en    = i_push && !i_flush && (!o_full || w_rd_en);
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;

        if (i_flush) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
            w_count_d  = '0;
        end else begin
            if (w_wr_en) begin
                w_wr_ptr_d = r_wr_ptr_q + C_PTR_ONE;
            end
            if (w_rd_en) begin
                w_rd_ptr_d = r_rd_ptr_q + C_PTR_ONE;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   w_count_d = r_count_q + C_CNT_ONE;
                2'b01:   w_count_d = r_count_q - C_CNT_ONE;
                default: w_count_d = r_count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_q[r_wr_ptr_q] <= i_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/gpu_cmd_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : gpu_cmd_queue                                               |
// | Purpose    : Buffers raster commands from the CPU and issues them one at |
// |              a time to the rasterizer with a one-cycle execute strobe,   |
// |              tracking the rasterizer busy handshake.                     |
// | Ports      : clk  system clock (rising edge)                             |
// |              rst  synchronous active-high reset                          |
// |              bus  gpu_cmd_queue_if.slave: push/in_*/flush/full/count/    |
// |                   idle on the CPU side; gpu_* operands,                  |
// |                   gpu_execute_request and gpu_busy on the GPU side       |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module gpu_cmd_queue
    import common::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    gpu_cmd_queue_if.slave    bus
);

    localparam int C_ENTRY_W = $bits(gpu_cmd_entry_t);

    gpu_cmd_entry_t           w_fifo_wdata;
    gpu_cmd_entry_t           w_fifo_rdata;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic [$clog2(DEPTH):0]   w_fifo_count;
    logic                     w_pop;

    gpu_fsm_state_t           r_state_q;
    gpu_fsm_state_t           w_state_d;
    logic                     r_ack_wait_q;   // one ACK cycle already seen without busy
    logic                     w_ack_wait_d;
    gpu_cmd_entry_t           r_op_q;         // operands of the command last popped
    gpu_cmd_entry_t           w_op_d;

    assign w_fifo_wdata = '{
        command: bus.in_command,
        x0:      bus.in_x0,
        y0:      bus.in_y0,
        x1:      bus.in_x1,
        y1:      bus.in_y1,
        colour:  bus.in_colour
    };

    cmd_fifo #(
        .WIDTH (C_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (bus.push),
        .i_pop   (w_pop),
        .i_flush (bus.flush),
        .i_wdata (w_fifo_wdata),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Next-state and pop decision. A flush only touches the FIFO, so a
    // command already popped carries on through ISSUE/ACK/RUN untouched.
    always_comb begin
        w_state_d    = r_state_q;
        w_ack_wait_d = 1'b0;
        w_op_d       = r_op_q;
        w_pop        = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                if (!w_fifo_empty && !bus.gpu_busy) begin
                    w_pop     = 1'b1;
                    w_op_d    = w_fifo_rdata;
                    w_state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_d = ST_ACK;
            end
            ST_ACK: begin
                // Two quiet ACK cycles mean the rasterizer finished instantly.
                if (bus.gpu_busy) begin
                    w_state_d = ST_RUN;
                end else if (r_ack_wait_q) begin
                    w_state_d = ST_IDLE;
                end else begin
                    w_ack_wait_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (!bus.gpu_busy) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= ST_IDLE;
            r_ack_wait_q <= 1'b0;
            r_op_q       <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_ack_wait_q <= w_ack_wait_d;
            r_op_q       <= w_op_d;
        end
    end

    // Status outputs depend on registered state and gpu_busy only.
    assign bus.full  = w_fifo_full;
    assign bus.count = w_fifo_count;
    assign bus.idle  = w_fifo_empty && (r_state_q == ST_IDLE) && !bus.gpu_busy;

    assign bus.gpu_execute_request = (r_state_q == ST_ISSUE);
    assign bus.gpu_command         = r_op_q.command;
    assign bus.gpu_x0              = r_op_q.x0;
    assign bus.gpu_y0              = r_op_q.y0;
    assign bus.gpu_x1              = r_op_q.x1;
    assign bus.gpu_y1              = r_op_q.y1;
    assign bus.gpu_colour          = r_op_q.colour;

endmodule
`default_nettype wire

// File: doc/gpu_cmd_queue.md
GPU_CMD_QUEUE -- requirements
Module: gpu_cmd_queue

Interface
REQ-001 The block SHALL take parameter DEPTH, default 4, meaning the number of command entries; it SHALL be a power of two and at least 2.
REQ-002 clk  input  1  system clock (50 MHz domain); all logic SHALL be clocked on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 push  input  1  CPU enqueue strobe, one entry per cycle while high.
REQ-005 in_command  input  raster_command_t  command to enqueue.
REQ-006 in_x0, in_y0, in_x1, in_y1  input  8 each  coordinates to enqueue.
REQ-007 in_colour  input  3  colour to enqueue.
REQ-008 flush  input  1  discard all queued (not yet issued) entries.
REQ-009 full  output  1  high when the queue holds DEPTH entries.
REQ-010 count  output  $clog2(DEPTH)+1  number of queued entries.
REQ-011 idle  output  1  high when the queue is empty, the FSM is IDLE and gpu_busy is low.
REQ-012 gpu_command, gpu_x0, gpu_y0, gpu_x1, gpu_y1, gpu_colour  output  raster_command_t/8/8/8/8/3  operands of the issued command, registered.
REQ-013 gpu_execute_request  output  1  one-cycle issue strobe to the rasterizer.
REQ-014 gpu_busy  input  1  rasterizer busy flag.

Function
REQ-015 Storage SHALL be a circular FIFO with DEPTH entries and wrapping read/write pointers.
REQ-016 A push while full SHALL be dropped, with no pointer, count or data change.
REQ-017 A push and an FSM pop in the same cycle SHALL leave count unchanged, including when full; the push SHALL be accepted when full only if a pop occurs that cycle.
REQ-018 The FSM SHALL have the states IDLE, ISSUE, ACK and RUN.
REQ-019 IDLE: if count>0 and gpu_busy=0, it SHALL pop the head into the gpu_* operand registers and go to ISSUE next cycle.
REQ-020 ISSUE: gpu_execute_request SHALL be 1 for exactly this one cycle, then the FSM SHALL go to ACK.
REQ-021 ACK: on gpu_busy=1 the FSM SHALL go to RUN; if gpu_busy stays 0 for 2 consecutive ACK cycles, it SHALL go to IDLE (zero-length command).
REQ-022 RUN: the FSM SHALL stay while gpu_busy=1 and go to IDLE when gpu_busy=0.
REQ-023 The gpu_* operand outputs SHALL stay stable from ISSUE until the next pop.
REQ-024 Minimum issue-to-issue spacing SHALL be 4 cycles.
REQ-025 Latency from a push into an empty queue with an idle rasterizer SHALL be: pop on cycle N+1, gpu_execute_request on cycle N+2.
REQ-026 flush SHALL empty the queue (pointers equal, count=0) next cycle and SHALL NOT abort an already issued command; the FSM SHALL continue normally.
REQ-027 flush and push in the same cycle: flush SHALL win and the pushed entry SHALL be discarded.
REQ-028 Outputs full, count and idle SHALL be combinational from registered state and gpu_busy only, with no combinational path from push.

Reset
REQ-029 On rst=1 at a clock edge, the block SHALL go to: FSM IDLE, pointers 0, count 0, full 0, gpu_execute_request 0, all gpu_* operands 0.
REQ-030 Reset mid-command SHALL abandon the command; after reset the block SHALL wait for gpu_busy=0 in IDLE before issuing.
REQ-031 FIFO data storage SHALL NOT require reset.

Structure
REQ-032 raster_command_t SHALL remain in package common; a queue-entry struct gpu_cmd_entry_t (command, x0, y0, x1, y1, colour) and the FSM state enum SHALL be added to common.
REQ-033 The storage SHALL be one sub-module, cmd_fifo (parameterised width and depth, push/pop/flush, full/empty/count); the FSM SHALL live in gpu_cmd_queue.
REQ-034 The block SHALL be instantiated between the CPU and the rasterizer at top level, driving the existing gpu_* nets.

Verification
REQ-035 Reset then push one LINE (0,0)->(10,20) colour 3 with gpu_busy held 0 -> gpu_execute_request pulses once at cycle +2 with operands 0,0,10,20,3; count returns to 0.
REQ-036 Push 5 entries with DEPTH=4 while gpu_busy=1 -> full=1 after the 4th push, the 5th is dropped, count=4; release busy -> exactly 4 issues in FIFO order.
REQ-037 Rasterizer model holds busy for 10 cycles after each request, 3 entries queued -> requests are spaced at least 12 cycles apart, never issued while busy=1, operands stable throughout.
REQ-038 gpu_busy never rises after a request -> FSM returns to IDLE after 2 ACK cycles and issues the next entry.
REQ-039 With 3 entries queued and one running, assert flush together with push -> count=0 next cycle, the running command completes, no further requests, idle=1 after busy falls.
REQ-040 Assert rst during RUN with 2 entries queued -> next cycle count=0, gpu_execute_request=0, operands 0; no request until after busy falls and a new push arrives.
